// File: rtl/dbscan_if.sv
// Point-stream handshake between a point source and the clustering engine.
interface dbscan_if #(
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [CW-1:0] in_x;
  logic [CW-1:0] in_y;
  logic [CW-1:0] in_z;

  modport master (output in_valid, in_last, in_x, in_y, in_z, input in_ready);
  modport slave  (input in_valid, in_last, in_x, in_y, in_z, output in_ready);
endinterface

// File: rtl/dbscan_engine.sv
// Brute-force DBSCAN over one buffered frame: a core-count pass, then a
// FIFO-driven cluster expansion, one point pair compared per cycle.
module dbscan_engine #(
  parameter  int MAX_N   = 64,
  parameter  int CW      = 8,
  parameter  int LW      = 4,
  parameter  int EPS2    = 4,
  parameter  int MIN_PTS = 3,
  localparam int NPW     = $clog2(MAX_N + 1),
  localparam int AW      = $clog2(MAX_N)
) (
  input  logic           clk,
  input  logic           rst,
  dbscan_if.slave        in_if,
  output logic           busy,
  output logic           done,
  output logic           overflow,
  output logic [NPW-1:0] num_points,
  output logic [LW-1:0]  num_clusters,
  input  logic [AW-1:0]  rd_addr,
  output logic [LW-1:0]  rd_label,
  output logic           rd_core
);
  localparam int DW = 2 * CW + 2;
  localparam int unsigned MINP = MIN_PTS;

  typedef enum logic [1:0] {LOAD, CORE, EXPAND, DONE} state_t;
  state_t r_state, w_state_nx;

  logic [CW-1:0]    r_px [MAX_N];
  logic [CW-1:0]    r_py [MAX_N];
  logic [CW-1:0]    r_pz [MAX_N];
  logic [LW-1:0]    r_label [MAX_N];
  logic [AW-1:0]    r_fifo [MAX_N];
  logic [MAX_N-1:0] r_core;
  logic [NPW-1:0]   r_num, r_i, r_j, r_cnt, r_wptr, r_rptr;
  logic [AW-1:0]    r_p;
  logic             r_scan, r_ovf;
  logic [LW-1:0]    r_cur, r_ncl;

  logic [AW-1:0]    w_ia, w_ib, w_wr_idx, w_push_idx;
  logic [DW-1:0]    w_dist;
  logic [NPW-1:0]   w_cnt_nx, w_nm1;
  logic [LW-1:0]    w_cur_inc;
  logic             w_near, w_full, w_acc, w_drop, w_last_i, w_last_j;
  logic             w_fifo_ne, w_seed_end, w_push;

  // Exact squared distance; operands widened first so no product truncates.
  function automatic logic [DW-1:0] dist2(input logic [CW-1:0] ax, ay, az,
                                          input logic [CW-1:0] bx, by, bz);
    logic [DW-1:0] dx, dy, dz;
    dx = DW'((ax >= bx) ? ax - bx : bx - ax);
    dy = DW'((ay >= by) ? ay - by : by - ay);
    dz = DW'((az >= bz) ? az - bz : bz - az);
    return dx * dx + dy * dy + dz * dz;
  endfunction

  // Clusters beyond the label range all share the top label.
  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v == {LW{1'b1}}) ? v : v + LW'(1);
  endfunction

  assign w_ia       = (r_state == EXPAND) ? r_p : r_i[AW-1:0];
  assign w_ib       = r_j[AW-1:0];
  assign w_dist     = dist2(r_px[w_ia], r_py[w_ia], r_pz[w_ia],
                            r_px[w_ib], r_py[w_ib], r_pz[w_ib]);
  assign w_near     = (w_dist <= DW'(EPS2));
  assign w_cnt_nx   = r_cnt + NPW'(w_near);
  assign w_nm1      = r_num - NPW'(1);
  assign w_last_i   = (r_i == w_nm1);
  assign w_last_j   = (r_j == w_nm1);
  assign w_full     = (r_num == NPW'(MAX_N));
  assign w_fifo_ne  = (r_rptr != r_wptr);
  assign w_seed_end = (r_i == r_num);
  assign w_cur_inc  = sat_inc(r_cur);

  // A finished frame always makes room for the next one.
  assign in_if.in_ready = !rst && ((r_state == LOAD && !w_full) || r_state == DONE);
  assign w_acc    = in_if.in_valid && in_if.in_ready;
  assign w_drop   = in_if.in_valid && (r_state == LOAD) && w_full;
  assign w_wr_idx = (r_state == DONE) ? '0 : r_num[AW-1:0];

  assign w_push = (r_state == EXPAND) &&
                  ((r_scan && w_near && r_label[w_ib] == '0 && r_core[w_ib]) ||
                   (!r_scan && !w_fifo_ne && !w_seed_end &&
                    r_core[r_i[AW-1:0]] && r_label[r_i[AW-1:0]] == '0));
  assign w_push_idx = r_scan ? w_ib : r_i[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      LOAD:   if ((w_acc || w_drop) && in_if.in_last) w_state_nx = CORE;
      CORE:   if (w_last_i && w_last_j) w_state_nx = EXPAND;
      EXPAND: if (!r_scan && !w_fifo_ne && w_seed_end) w_state_nx = DONE;
      DONE:   if (w_acc) w_state_nx = in_if.in_last ? CORE : LOAD;
      default: w_state_nx = LOAD;
    endcase
  end

  // Point and FIFO storage carry no reset; occupancy is tracked by r_num and pointers.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_px[w_wr_idx] <= in_if.in_x;
      r_py[w_wr_idx] <= in_if.in_y;
      r_pz[w_wr_idx] <= in_if.in_z;
    end
    if (w_push) r_fifo[r_wptr[AW-1:0]] <= w_push_idx;
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == DONE && w_acc)) begin
      r_num  <= rst ? '0 : NPW'(1);
      r_ovf  <= 1'b0;
      r_ncl  <= '0;
      r_cur  <= '0;
      r_core <= '0;
      for (int k = 0; k < MAX_N; k++) r_label[k] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_cnt  <= '0;
      r_scan <= 1'b0;
      r_p    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + NPW'(1);
      case (r_state)
        LOAD: begin
          if (w_acc)  r_num <= r_num + NPW'(1);
          if (w_drop) r_ovf <= 1'b1;
          r_i   <= '0;
          r_j   <= '0;
          r_cnt <= '0;
        end
        CORE: begin
          r_j   <= r_j + NPW'(1);
          r_cnt <= w_cnt_nx;
          if (w_last_j) begin
            r_core[r_i[AW-1:0]] <= (32'(w_cnt_nx) >= MINP);
            r_cnt <= '0;
            r_j   <= '0;
            r_i   <= w_last_i ? '0 : r_i + NPW'(1);
          end
        end
        EXPAND: begin
          if (r_scan) begin
            if (w_near && r_label[w_ib] == '0) r_label[w_ib] <= r_cur;
            r_j <= w_last_j ? '0 : r_j + NPW'(1);
            if (w_last_j) r_scan <= 1'b0;
          end else if (w_fifo_ne) begin
            r_p    <= r_fifo[r_rptr[AW-1:0]];
            r_rptr <= r_rptr + NPW'(1);
            r_scan <= 1'b1;
            r_j    <= '0;
          end else if (!w_seed_end) begin
            if (w_push) begin
              r_cur <= w_cur_inc;
              r_label[r_i[AW-1:0]] <= w_cur_inc;
            end
            r_i <= r_i + NPW'(1);
          end else begin
            r_ncl <= r_cur;
          end
        end
        default: begin
          r_i   <= '0;
          r_j   <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign busy         = (r_state == CORE) || (r_state == EXPAND);
  assign done         = (r_state == DONE);
  assign overflow     = r_ovf;
  assign num_points   = r_num;
  assign num_clusters = r_ncl;
  assign rd_label     = (done && NPW'(rd_addr) < r_num) ? r_label[rd_addr] : '0;
  assign rd_core      = (done && NPW'(rd_addr) < r_num) ? r_core[rd_addr] : 1'b0;
endmodule

// File: tb/tb_dbscan_engine.sv
// Directed bench: instance A (MAX_N=8, LW=4) for the main cases, instance B
// (MAX_N=16, LW=2) for label saturation.
module tb_dbscan_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dbscan_if #(.CW(8)) ifa ();
  dbscan_if #(.CW(8)) ifb ();

  logic       busy_a, done_a, ovf_a, rc_a;
  logic [3:0] np_a, ncl_a, rl_a;
  logic [2:0] ra_a;
  logic       busy_b, done_b, ovf_b, rc_b;
  logic [4:0] np_b;
  logic [1:0] ncl_b, rl_b;
  logic [3:0] ra_b;

  dbscan_engine #(.MAX_N(8), .CW(8), .LW(4), .EPS2(4), .MIN_PTS(3)) dut_a (
    .clk(clk), .rst(rst), .in_if(ifa), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .num_points(np_a), .num_clusters(ncl_a),
    .rd_addr(ra_a), .rd_label(rl_a), .rd_core(rc_a));

  dbscan_engine #(.MAX_N(16), .CW(8), .LW(2), .EPS2(4), .MIN_PTS(3)) dut_b (
    .clk(clk), .rst(rst), .in_if(ifb), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .num_points(np_b), .num_clusters(ncl_b),
    .rd_addr(ra_b), .rd_label(rl_b), .rd_core(rc_b));

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] px [16];
  logic [7:0] py [16];
  logic [7:0] pz [16];
  int elab [16];
  int ecore [16];
  logic rdy_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_pt(input int i, input int x, input int y, input int z,
                        input int lab, input int cr);
    px[i] = 8'(x); py[i] = 8'(y); pz[i] = 8'(z);
    elab[i] = lab; ecore[i] = cr;
  endtask

  task automatic beat(input int sel, input int i, input logic last);
    @(negedge clk);
    if (sel == 0) begin
      rdy_seen = ifa.in_ready;
      ifa.in_valid = 1'b1; ifa.in_x = px[i]; ifa.in_y = py[i]; ifa.in_z = pz[i];
      ifa.in_last = last;
    end else begin
      rdy_seen = ifb.in_ready;
      ifb.in_valid = 1'b1; ifb.in_x = px[i]; ifb.in_y = py[i]; ifb.in_z = pz[i];
      ifb.in_last = last;
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input int sel, input int n);
    for (int i = 0; i < n; i++) beat(sel, i, i == n - 1);
  endtask

  task automatic wait_done(input int sel, input int bound);
    int  cyc;
    logic seen;
    cyc = 0;
    seen = 1'b0;
    @(negedge clk);
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    for (int k = 0; k < bound + 20; k++) begin
      if ((sel == 0) ? done_a : done_b) begin
        seen = 1'b1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    check("done_seen", 32'(seen), 1);
    check("done_in_bound", 32'(cyc <= bound), 1);
  endtask

  task automatic verify_frame(input int sel, input int n, input int ncl);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel == 0) begin
        ra_a = 3'(i);
        #1;
        check($sformatf("label_a[%0d]", i), 32'(rl_a), elab[i]);
        check($sformatf("core_a[%0d]", i), 32'(rc_a), ecore[i]);
      end else begin
        ra_b = 4'(i);
        #1;
        check($sformatf("label_b[%0d]", i), 32'(rl_b), elab[i]);
        check($sformatf("core_b[%0d]", i), 32'(rc_b), ecore[i]);
      end
    end
    if (sel == 0) begin
      check("num_clusters_a", 32'(ncl_a), ncl);
      check("num_points_a", 32'(np_a), n);
      check("busy_a_idle", 32'(busy_a), 0);
    end else begin
      check("num_clusters_b", 32'(ncl_b), ncl);
      check("num_points_b", 32'(np_b), n);
      check("busy_b_idle", 32'(busy_b), 0);
    end
  endtask

  task automatic load_two_clusters();
    set_pt(0, 0, 0, 0, 1, 1);       set_pt(1, 1, 0, 0, 1, 1);
    set_pt(2, 0, 1, 0, 1, 1);       set_pt(3, 100, 100, 100, 2, 1);
    set_pt(4, 101, 100, 100, 2, 1); set_pt(5, 100, 101, 100, 2, 1);
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.in_last = 1'b0; ifa.in_x = '0; ifa.in_y = '0; ifa.in_z = '0;
    ifb.in_valid = 1'b0; ifb.in_last = 1'b0; ifb.in_x = '0; ifb.in_y = '0; ifb.in_z = '0;
    ra_a = '0; ra_b = '0;
    rst = 1'b1;
    @(negedge clk);
    check("ready_in_reset", 32'(ifa.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(ifa.in_ready), 1);
    check("busy_reset", 32'(busy_a), 0);
    check("done_reset", 32'(done_a), 0);
    check("ovf_reset", 32'(ovf_a), 0);
    check("np_reset", 32'(np_a), 0);
    check("ncl_reset", 32'(ncl_a), 0);
    check("rd_label_reset", 32'(rl_a), 0);

    // Two well-separated clusters.
    load_two_clusters();
    send_frame(0, 6);
    wait_done(0, 2 * 36 + 4 * 6 + 8);
    verify_frame(0, 6, 2);
    @(negedge clk);
    ra_a = 3'd6;
    #1;
    check("rd_beyond_n", 32'(rl_a), 0);

    // Same set plus an isolated noise point; starts from DONE.
    load_two_clusters();
    set_pt(6, 50, 50, 50, 0, 0);
    send_frame(0, 7);
    wait_done(0, 2 * 49 + 4 * 7 + 8);
    verify_frame(0, 7, 2);
    check("ovf_new_frame", 32'(ovf_a), 0);

    // Border point reached only from a core neighbour.
    set_pt(0, 0, 0, 0, 1, 1); set_pt(1, 1, 0, 0, 1, 1);
    set_pt(2, 2, 0, 0, 1, 1); set_pt(3, 4, 0, 0, 1, 0);
    send_frame(0, 4);
    wait_done(0, 2 * 16 + 4 * 4 + 8);
    verify_frame(0, 4, 1);

    // Reset in the middle of the core pass, then a clean frame.
    set_pt(0, 0, 0, 0, 1, 1); set_pt(1, 1, 0, 0, 1, 1); set_pt(2, 0, 1, 0, 1, 1);
    send_frame(0, 3);
    @(negedge clk);
    ifa.in_valid = 1'b0;
    @(negedge clk);
    check("busy_mid_core", 32'(busy_a), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_np", 32'(np_a), 0);
    check("rst_ready", 32'(ifa.in_ready), 1);
    send_frame(0, 3);
    wait_done(0, 2 * 9 + 4 * 3 + 8);
    verify_frame(0, 3, 1);

    // Overflow: ten isolated points into an eight-entry buffer.
    for (int i = 0; i < 10; i++) set_pt(i, i * 20, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      beat(0, i, i == 9);
      if (i == 8) check("ready_low_when_full", 32'(rdy_seen), 0);
    end
    @(negedge clk);
    ifa.in_valid = 1'b0;
    check("ovf_busy", 32'(busy_a), 1);
    check("ovf_flag", 32'(ovf_a), 1);
    check("ovf_np", 32'(np_a), 8);
    check("ready_low_busy", 32'(ifa.in_ready), 0);
    wait_done(0, 2 * 64 + 4 * 8 + 8);
    verify_frame(0, 8, 0);
    check("ovf_sticky", 32'(ovf_a), 1);

    // Four clusters with a 2-bit label: the last two share label 3.
    for (int c = 0; c < 4; c++) begin
      set_pt(3 * c + 0, 50 * c,     0, 0, (c < 3) ? c + 1 : 3, 1);
      set_pt(3 * c + 1, 50 * c + 1, 0, 0, (c < 3) ? c + 1 : 3, 1);
      set_pt(3 * c + 2, 50 * c,     1, 0, (c < 3) ? c + 1 : 3, 1);
    end
    send_frame(1, 12);
    wait_done(1, 2 * 144 + 4 * 12 + 8);
    verify_frame(1, 12, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
